// File: rtl/regfile_sb.sv
// Register file with per-register load-pending (busy) scoreboard and a registered pending count.
// Optional macro REGFILE_SB_BYPASS_EN forwards same-cycle write data and busy=0 onto matching reads.
module regfile_sb #(
    parameter int          W        = 32,
    parameter int          DEPTH    = 32,
    parameter int          LINK_REG = 31,
    parameter int          GP_IDX   = 28,
    parameter logic [31:0] GP_INIT  = 32'h10008000,
    parameter int          SP_IDX   = 29,
    parameter logic [31:0] SP_INIT  = 32'h7fffeffc,
    localparam int         AW       = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          regwrite,
    input  logic          link_in,
    input  logic [AW-1:0] wr_in,
    input  logic [W-1:0]  write_data_in,
    input  logic          mark_in,
    input  logic [AW-1:0] mark_addr_in,
    input  logic [AW-1:0] rr1_in,
    input  logic [AW-1:0] rr2_in,
    output logic [W-1:0]  rdata1_out,
    output logic [W-1:0]  rdata2_out,
    output logic          busy1_out,
    output logic          busy2_out,
    output logic [AW:0]   pending_cnt_out
);

    typedef logic [W-1:0] mem_t [DEPTH];

    function automatic mem_t f_preset();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) m[i] = '0;
        m[GP_IDX] = W'(GP_INIT);
        m[SP_IDX] = W'(SP_INIT);
        m[0]      = '0;
        return m;
    endfunction

    function automatic logic [AW:0] f_popcount(input logic [DEPTH-1:0] v);
        logic [AW:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) n = n + (AW+1)'(v[i]);
        return n;
    endfunction

    // Declaration initialisers give the reset image at time zero, before any reset edge.
    mem_t             r_mem   = f_preset();
    logic [DEPTH-1:0] r_busy  = '0;
    logic [AW:0]      r_cnt   = '0;

    logic [AW-1:0]    w_ea;
    logic             w_wr_acc;
    logic             w_mark_acc;
    logic [DEPTH-1:0] w_busy_nxt;

    assign w_ea       = link_in ? AW'(LINK_REG) : wr_in;
    assign w_wr_acc   = regwrite && !reset && (w_ea != '0);
    assign w_mark_acc = mark_in && !reset && (mark_addr_in != '0);

    // Clear on write first, then set on mark, so a same-cycle mark leaves the load outstanding.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_acc)   w_busy_nxt[w_ea]         = 1'b0;
        if (w_mark_acc) w_busy_nxt[mark_addr_in] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem  <= f_preset();
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr_acc) r_mem[w_ea] <= write_data_in;
            r_busy <= w_busy_nxt;
            r_cnt  <= f_popcount(w_busy_nxt);
        end
    end

    assign pending_cnt_out = r_cnt;

    always_comb begin
        rdata1_out = (rr1_in == '0) ? '0 : r_mem[rr1_in];
        rdata2_out = (rr2_in == '0) ? '0 : r_mem[rr2_in];
        busy1_out  = (rr1_in == '0) ? 1'b0 : r_busy[rr1_in];
        busy2_out  = (rr2_in == '0) ? 1'b0 : r_busy[rr2_in];
`ifdef REGFILE_SB_BYPASS_EN
        if (w_wr_acc && (rr1_in == w_ea)) begin
            rdata1_out = write_data_in;
            busy1_out  = 1'b0;
        end
        if (w_wr_acc && (rr2_in == w_ea)) begin
            rdata2_out = write_data_in;
            busy2_out  = 1'b0;
        end
`else
`endif
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues hand-computed expectations, monitor compares on negedge.
module tb_regfile_sb;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          regwrite = 1'b0;
    logic          link_in = 1'b0;
    logic [AW-1:0] wr_in = '0;
    logic [W-1:0]  write_data_in = '0;
    logic          mark_in = 1'b0;
    logic [AW-1:0] mark_addr_in = '0;
    logic [AW-1:0] rr1_in = '0;
    logic [AW-1:0] rr2_in = '0;
    logic [W-1:0]  rdata1_out;
    logic [W-1:0]  rdata2_out;
    logic          busy1_out;
    logic          busy2_out;
    logic [AW:0]   pending_cnt_out;

    regfile_sb dut (
        .clock(clock), .reset(reset), .regwrite(regwrite), .link_in(link_in),
        .wr_in(wr_in), .write_data_in(write_data_in), .mark_in(mark_in),
        .mark_addr_in(mark_addr_in), .rr1_in(rr1_in), .rr2_in(rr2_in),
        .rdata1_out(rdata1_out), .rdata2_out(rdata2_out),
        .busy1_out(busy1_out), .busy2_out(busy2_out),
        .pending_cnt_out(pending_cnt_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       nm;
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        logic        b1;
        logic        b2;
        logic [AW:0] cnt;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic drive(input logic rst, input logic we, input logic lnk,
                         input logic [AW-1:0] wa, input logic [W-1:0] wd,
                         input logic mk, input logic [AW-1:0] ma,
                         input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        reset = rst; regwrite = we; link_in = lnk; wr_in = wa; write_data_in = wd;
        mark_in = mk; mark_addr_in = ma; rr1_in = a1; rr2_in = a2;
    endtask

    task automatic expect_out(input string nm, input logic [W-1:0] d1, input logic [W-1:0] d2,
                              input logic b1, input logic b2, input logic [AW:0] cnt);
        exp_t e;
        e.nm = nm; e.d1 = d1; e.d2 = d2; e.b1 = b1; e.b2 = b2; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic cmp(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp({e.nm, ".rdata1"}, rdata1_out, e.d1);
            cmp({e.nm, ".rdata2"}, rdata2_out, e.d2);
            cmp({e.nm, ".busy1"},  W'(busy1_out), W'(e.b1));
            cmp({e.nm, ".busy2"},  W'(busy2_out), W'(e.b2));
            cmp({e.nm, ".cnt"},    W'(pending_cnt_out), W'(e.cnt));
        end
    end

    initial begin
        // Presets must be visible before any reset edge.
        drive(0, 0, 0, 0, 0, 0, 0, 28, 29);
        expect_out("preset_t0", 32'h10008000, 32'h7fffeffc, 0, 0, 0);
        @(negedge clock);
        #1;

        step(); drive(1, 1, 0, 3, 32'h99, 1, 3, 28, 29);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 28, 29);
        expect_out("reset_presets", 32'h10008000, 32'h7fffeffc, 0, 0, 0);

        step(); drive(0, 1, 0, 0, 32'hDEADBEEF, 0, 0, 0, 5);
        expect_out("wr_r0", 0, 0, 0, 0, 0);
        step(); drive(0, 1, 1, 5, 32'h400, 0, 0, 0, 5);
        expect_out("r0_zero", 0, 0, 0, 0, 0);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 31, 5);
        expect_out("link_wr", 32'h400, 0, 0, 0, 0);

        step(); drive(0, 0, 0, 0, 0, 1, 7, 7, 9);
        expect_out("mark7_pre", 0, 0, 0, 0, 0);
        step(); drive(0, 0, 0, 0, 0, 1, 9, 7, 9);
        expect_out("mark7_post", 0, 0, 1, 0, 1);
        step(); drive(0, 1, 0, 7, 32'h55, 0, 0, 7, 9);
        expect_out("wr7_same", BYP ? 32'h55 : 32'h0, 0, !BYP, 1, 2);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 7, 9);
        expect_out("wr7_clear", 32'h55, 0, 0, 1, 1);

        step(); drive(0, 1, 0, 12, 32'hAA, 1, 12, 12, 9);
        expect_out("mark_wr12", BYP ? 32'hAA : 32'h0, 0, 0, 1, 1);
        step(); drive(0, 0, 0, 0, 0, 1, 12, 12, 0);
        expect_out("mark_wins", 32'hAA, 0, 1, 0, 2);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 12, 9);
        expect_out("remark_nochg", 32'hAA, 0, 1, 1, 2);

        step(); drive(0, 1, 0, 3, 32'h33, 1, 0, 3, 0);
        expect_out("wr3_mark0", BYP ? 32'h33 : 32'h0, 0, 0, 0, 2);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 3, 0);
        expect_out("mark0_noeff", 32'h33, 0, 0, 0, 2);

        step(); drive(1, 1, 0, 3, 32'h77, 1, 5, 3, 12);
        expect_out("rst_pending", 32'h33, 32'hAA, 0, 1, 2);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 3, 12);
        expect_out("rst_prio", 0, 0, 0, 0, 0);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 5, 9);
        expect_out("rst_busy_clr", 0, 0, 0, 0, 0);

        step(); drive(0, 1, 0, 4, 32'h1234, 0, 0, 4, 7);
        expect_out("byp_same", BYP ? 32'h1234 : 32'h0, 0, 0, 0, 0);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 4, 28);
        expect_out("byp_next", 32'h1234, 32'h10008000, 0, 0, 0);

        step(); drive(0, 1, 0, 9, 32'h9, 0, 0, 9, 31);
        expect_out("post_rst_wr", BYP ? 32'h9 : 32'h0, 0, 0, 0, 0);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 9, 31);
        expect_out("post_rst_rd", 32'h9, 0, 0, 0, 0);

        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
